xor_gate: RTL and testbench
===========================

# xor_gate

Bitwise XOR datapath primitive with a registered observation path. Output `c` is the purely combinational XOR of `a` and `b`. A clocked side path registers the result and keeps running parity and difference statistics for debug and self-check. It sits wherever a mismatch/compare or parity term is needed and the surrounding logic also wants per-cycle bookkeeping.

## Interface
- `WIDTH`, default 1: bit width of `a`, `b`, `c`, `c_q`.
- `CNT_W`, default 16: width of `diff_cnt`.
- `PC_W`, default `$clog2(WIDTH+1)`, minimum 1: width of `pop_q`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `en`  in  1  statistics enable.
- `clr`  in  1  synchronous clear of the statistics.
- `c`  out  WIDTH  `a ^ b`, combinational.
- `c_q`  out  WIDTH  `c` registered.
- `eq_q`  out  1  registered `(a == b)`.
- `pop_q`  out  PC_W  registered popcount of `c`.
- `par_acc`  out  1  running parity accumulator.
- `diff_cnt`  out  CNT_W  saturating count of enabled cycles with `c != 0`.

## Operation
- `c = a ^ b` bitwise, at all times.
  - No dependence on `clk`, `rst_n`, `en` or `clr`.
  - Valid even with `clk` idle or `rst_n` unknown.
- `c_q`, `eq_q` and `pop_q` load every rising edge, unconditionally (not gated by `en` or `clr`).
  - `c_q <= a ^ b`
  - `eq_q <= (a == b)`
  - `pop_q <=` number of 1 bits in `a ^ b`.
- Statistics update, in priority order:
  1. `clr = 1`: `par_acc <= 0`, `diff_cnt <= 0`. Takes priority over `en`.
  2. `en = 1`: `par_acc <= par_acc ^ (^(a ^ b))`.
     - `diff_cnt` increments by 1 if `(a ^ b) != 0`.
     - `diff_cnt` saturates at `2^CNT_W - 1` and never wraps.
  3. Otherwise: hold.
- Width rules:
  - All operands are unsigned.
  - No sign extension.
  - `pop_q` range is 0..WIDTH.
- Integration tie-offs where statistics are unused: `en = 0`, `clr = 0`. Unused registered outputs may be left open.

## Timing
- `c`: zero-cycle, combinational path only.
- `c_q`, `eq_q`, `pop_q`, `par_acc`, `diff_cnt`: 1-cycle latency from the sampled inputs.
- Reset values, applied immediately on `rst_n` falling (asynchronous):
  - `c_q = 0`
  - `eq_q = 1` (consistent with `a = b = 0`)
  - `pop_q = 0`
  - `par_acc = 0`
  - `diff_cnt = 0`
- Reset release is synchronous to `clk`. The first update occurs on the first rising edge with `rst_n = 1`.
- Reset asserted mid-operation: all registers clear at once and hold while `rst_n = 0`. `c` keeps tracking `a ^ b`.
- Simultaneous `clr` and `en`: clear wins. The current cycle's XOR is not counted.
- Saturated `diff_cnt` with a further differing cycle: value stays at max.
- `a`, `b`, `en`, `clr` are synchronous to `clk` and must meet setup/hold for the registered path.

## Test plan
- Combinational truth table, WIDTH=1, no clock running: (a,b) = (0,0),(0,1),(1,0),(1,1) → `c` = 0,1,1,0, each within 1 ns of the input change.
- Reset: drive `rst_n = 0` with a=1, b=0 → immediately `c_q = 0`, `eq_q = 1`, `pop_q = 0`, `par_acc = 0`, `diff_cnt = 0`, and `c = 1`.
- Registered path, WIDTH=4, en=1: a=4'b1100, b=4'b1010 at edge N → `c = 4'b0110` immediately. After edge N: `c_q = 4'b0110`, `eq_q = 0`, `pop_q = 2`, `diff_cnt = 1`, `par_acc = 0`.
- Parity/count accumulation, WIDTH=1, en=1: inputs (1,0),(0,0),(1,1),(0,1) over 4 cycles → `diff_cnt = 2`, `par_acc = 0`. One more (1,0) → `diff_cnt = 3`, `par_acc = 1`.
- Clear priority: `clr = 1` and `en = 1` with a≠b at one edge → `diff_cnt = 0`, `par_acc = 0` after that edge. With `en = 0`, a≠b → counters hold.
- Saturation, CNT_W=2: 5 consecutive cycles with en=1, a≠b → `diff_cnt` sequence 1,2,3,3,3.

Source files
------------

// File: rtl/xor_gate.sv
// Purpose : bitwise XOR primitive with a registered observation path and running parity/difference statistics.
// Latency : c is combinational (0 cycles); c_q, eq_q, pop_q, par_acc, diff_cnt update 1 cycle after the sampled inputs.
// Backpr. : none; there is no handshake, so every rising edge samples a/b/en/clr unconditionally.
//
// Ports:
//   clk, rst_n      single clock, asynchronous active-low reset
//   a, b            operands (unsigned, WIDTH bits)
//   en, clr         statistics enable / synchronous clear (clr wins)
//   c               a ^ b, combinational
//   c_q, eq_q       registered a ^ b and registered (a == b)
//   pop_q           registered popcount of a ^ b (0..WIDTH)
//   par_acc         running XOR-reduction of every enabled cycle's a ^ b
//   diff_cnt        saturating count of enabled cycles with a != b
module xor_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    parameter int PC_W  = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             eq_q,
    output logic [PC_W-1:0]  pop_q,
    output logic             par_acc,
    output logic [CNT_W-1:0] diff_cnt
);

    // Observation snapshot loaded every edge, independent of en/clr.
    typedef struct packed {
        logic [WIDTH-1:0] xr;
        logic             eq;
        logic [PC_W-1:0]  pop;
    } obs_t;

    // Statistics state, gated by en and cleared by clr.
    typedef struct packed {
        logic             par;
        logic [CNT_W-1:0] cnt;
    } stat_t;

    logic [WIDTH-1:0] xr;
    logic [PC_W-1:0]  pop_nxt;
    logic             any_diff;
    logic             xr_par;
    obs_t             obs_d;
    obs_t             obs_q;
    stat_t            stat_d;
    stat_t            stat_q;

    // The only path that does not touch a flop: valid with clk idle or rst_n unknown.
    assign xr = a ^ b;
    assign c  = xr;

    assign any_diff = |xr;
    assign xr_par   = ^xr;

    always_comb begin
        pop_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_nxt = pop_nxt + PC_W'(xr[i]);
        end
    end

    always_comb begin
        obs_d     = '0;
        obs_d.xr  = xr;
        obs_d.eq  = (a == b);
        obs_d.pop = pop_nxt;
    end

    // clr has priority over en so a clearing cycle never counts its own XOR;
    // the counter sticks at all-ones rather than wrapping.
    always_comb begin
        stat_d = stat_q;
        if (clr) begin
            stat_d = '0;
        end else if (en) begin
            stat_d.par = stat_q.par ^ xr_par;
            if (any_diff && (stat_q.cnt != {CNT_W{1'b1}})) begin
                stat_d.cnt = stat_q.cnt + CNT_W'(1);
            end
        end
    end

    // eq resets to 1 so the idle observation matches a = b = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obs_q.xr  <= '0;
            obs_q.eq  <= 1'b1;
            obs_q.pop <= '0;
        end else begin
            obs_q <= obs_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign c_q      = obs_q.xr;
    assign eq_q     = obs_q.eq;
    assign pop_q    = obs_q.pop;
    assign par_acc  = stat_q.par;
    assign diff_cnt = stat_q.cnt;

endmodule

// File: tb/tb_xor_gate.sv
// Purpose : self-checking bench for xor_gate: WIDTH=4/CNT_W=16 table run and WIDTH=1/CNT_W=2 corner sequences.
// Latency : expectations are queued at drive time and popped one edge later, sampled 1 ns after the rising edge.
// Backpr. : none; the bench drives every cycle.
module tb_xor_gate;

    logic clk;
    logic clk_run;
    logic rst_n;

    // WIDTH=4 instance
    logic [3:0]  a4, b4, c4, c_q4;
    logic        en4, clr4, eq_q4, par4;
    logic [2:0]  pop4;
    logic [15:0] cnt4;

    // WIDTH=1, CNT_W=2 instance
    logic        a1, b1, c1, c_q1;
    logic        en1, clr1, eq_q1, par1;
    logic        pop1;
    logic [1:0]  cnt1;

    xor_gate #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .en(en4), .clr(clr4),
        .c(c4), .c_q(c_q4), .eq_q(eq_q4), .pop_q(pop4), .par_acc(par4), .diff_cnt(cnt4)
    );

    xor_gate #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .en(en1), .clr(clr1),
        .c(c1), .c_q(c_q1), .eq_q(eq_q1), .pop_q(pop1), .par_acc(par1), .diff_cnt(cnt1)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        logic        en;
        logic        clr;
        logic [3:0]  c;
        logic        eq;
        logic [2:0]  pop;
        logic        par;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0]  c;
        logic        eq;
        logic [2:0]  pop;
        logic        par;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    task automatic push(input logic [3:0] c, input logic eq, input logic [2:0] pop,
                        input logic par, input logic [15:0] cnt);
        exp_t e;
        e.c = c; e.eq = eq; e.pop = pop; e.par = par; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // One WIDTH=4 cycle: drive at the falling edge, check c at once, registered outputs after the rising edge.
    task automatic step4(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        a4 = v.a; b4 = v.b; en4 = v.en; clr4 = v.clr;
        push(v.c, v.eq, v.pop, v.par, v.cnt);
        #1;
        check({tag, ".c"}, 32'(c4), 32'(v.c));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ".c_q"}, 32'(c_q4), 32'(e.c));
            check({tag, ".eq_q"}, 32'(eq_q4), 32'(e.eq));
            check({tag, ".pop_q"}, 32'(pop4), 32'(e.pop));
            check({tag, ".par_acc"}, 32'(par4), 32'(e.par));
            check({tag, ".diff_cnt"}, 32'(cnt4), 32'(e.cnt));
        end
    endtask

    task automatic step1(input logic a, input logic b, input logic en, input logic clr,
                         input logic par, input logic [1:0] cnt, input string tag);
        exp_t e;
        @(negedge clk);
        a1 = a; b1 = b; en1 = en; clr1 = clr;
        push({3'b000, a ^ b}, (a == b), {2'b00, a ^ b}, par, {14'd0, cnt});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, ".c_q"}, 32'(c_q1), 32'(e.c));
            check({tag, ".eq_q"}, 32'(eq_q1), 32'(e.eq));
            check({tag, ".pop_q"}, 32'(pop1), 32'(e.pop));
            check({tag, ".par_acc"}, 32'(par1), 32'(e.par));
            check({tag, ".diff_cnt"}, 32'(cnt1), 32'(e.cnt));
        end
    endtask

    vec_t tbl[8];

    initial begin
        // a, b, en, clr -> c, eq, pop, par, cnt (state carried from the previous row)
        tbl[0] = '{4'hC, 4'hA, 1'b1, 1'b0, 4'h6, 1'b0, 3'd2, 1'b0, 16'd1};
        tbl[1] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 3'd0, 1'b0, 16'd1};
        tbl[2] = '{4'hF, 4'h0, 1'b1, 1'b0, 4'hF, 1'b0, 3'd4, 1'b0, 16'd2};
        tbl[3] = '{4'h1, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0, 3'd1, 1'b1, 16'd3};
        tbl[4] = '{4'h7, 4'h0, 1'b0, 1'b0, 4'h7, 1'b0, 3'd3, 1'b1, 16'd3};
        tbl[5] = '{4'h8, 4'h0, 1'b1, 1'b1, 4'h8, 1'b0, 3'd1, 1'b0, 16'd0};
        tbl[6] = '{4'h3, 4'h1, 1'b1, 1'b0, 4'h2, 1'b0, 3'd1, 1'b1, 16'd1};
        tbl[7] = '{4'h5, 4'h5, 1'b0, 1'b1, 4'h0, 1'b1, 3'd0, 1'b0, 16'd0};

        clk_run = 1'b0;
        rst_n = 1'b1;
        a4 = '0; b4 = '0; en4 = 1'b0; clr4 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; en1 = 1'b0; clr1 = 1'b0;

        // Combinational truth table with the clock stopped and reset untouched.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0];
            #1;
            check("truth.c", 32'(c1), 32'(ab[1] ^ ab[0]));
        end

        // Asynchronous reset, no clock: registers clear at once, c still follows a ^ b.
        a1 = 1'b1; b1 = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst.c_q", 32'(c_q1), 32'd0);
        check("rst.eq_q", 32'(eq_q1), 32'd1);
        check("rst.pop_q", 32'(pop1), 32'd0);
        check("rst.par_acc", 32'(par1), 32'd0);
        check("rst.diff_cnt", 32'(cnt1), 32'd0);
        check("rst.c", 32'(c1), 32'd1);
        check("rst.w4.eq_q", 32'(eq_q4), 32'd1);
        check("rst.w4.diff_cnt", 32'(cnt4), 32'd0);

        clk_run = 1'b1;
        a1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table run on the WIDTH=4 instance.
        for (int i = 0; i < 8; i++) begin
            step4(tbl[i], $sformatf("tbl%0d", i));
        end

        // Build some state, then reset mid-operation between edges.
        step4('{4'h9, 4'h0, 1'b1, 1'b0, 4'h9, 1'b0, 3'd2, 1'b0, 16'd1}, "pre_rst");
        @(negedge clk);
        a4 = 4'h6; b4 = 4'h3;
        rst_n = 1'b0;
        #1;
        check("midrst.c_q", 32'(c_q4), 32'd0);
        check("midrst.eq_q", 32'(eq_q4), 32'd1);
        check("midrst.pop_q", 32'(pop4), 32'd0);
        check("midrst.diff_cnt", 32'(cnt4), 32'd0);
        check("midrst.c", 32'(c4), 32'h5);
        @(posedge clk);
        #1;
        check("midrst.hold.c_q", 32'(c_q4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a4 = '0; b4 = '0; en4 = 1'b0; clr4 = 1'b0;

        // WIDTH=1 parity/count accumulation.
        step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, "acc0");
        step1(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, "acc1");
        step1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, "acc2");
        step1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, "acc3");
        step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, "acc4");

        // clr beats en, then en=0 holds.
        step1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, "clr_en");
        step1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, "hold");

        // Saturation at 2^CNT_W - 1.
        step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, "sat0");
        step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, "sat1");
        step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, "sat2");
        step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, "sat3");
        step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, "sat4");

        check("sb.drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
